// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Shared types and default sizes for the instruction fetch front end.
//   word            : 32-bit machine word
//   fetch_entry_t   : {address, instruction} pair buffered for decode
//   tracker_entry_t : {address, kill} for a granted-but-unanswered request
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

  typedef logic [31:0] word;

  typedef struct packed {
    word addr;
    word instruction;
  } fetch_entry_t;

  typedef struct packed {
    word  addr;
    logic kill;
  } tracker_entry_t;

  localparam int FETCH_QUEUE_DEPTH     = 4;
  localparam int FETCH_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Type-generic circular buffer with push/pop/clear, an occupancy count and a
// per-slot kill flag that can be raised on every stored entry at once.
// Ports:
//   i_clock, i_rst_n      : clock, asynchronous active-low reset
//   i_push, i_push_data   : write at the tail (accepted when not full, or when
//                           a pop frees the slot in the same cycle)
//   i_pop                 : remove the head (ignored when empty)
//   i_clear               : drop every entry; overrides push and pop
//   i_kill_all            : mark every entry stored before this edge as killed
//   o_head, o_head_kill   : head entry and its kill flag
//   o_count               : number of stored entries
//   o_live_count          : number of stored entries that are not killed
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                         i_clock,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  T                             i_push_data,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  logic                         i_kill_all,
  output T                             o_head,
  output logic                         o_head_kill,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_live_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  T                 r_mem [DEPTH];
  logic [DEPTH-1:0] r_kill;

  logic [DEPTH-1:0] w_valid;
  logic [CW-1:0]    w_live;
  logic             w_empty;
  logic             w_full;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_doPop  = i_pop && !w_empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_doPush = i_push && (!w_full || w_doPop);

  // A slot holds a live entry when its distance from the read pointer is
  // below the occupancy; kill flags of empty slots are don't-care.
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = (((i >= int'(r_rd)) ? (i - int'(r_rd))
                                        : (i + DEPTH - int'(r_rd))) < int'(r_count));
    end
  end

  always_comb begin
    w_live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && !r_kill[i]) begin
        w_live = w_live + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wr <= nextPtr(r_wr);
      end
      if (w_doPop) begin
        r_rd <= nextPtr(r_rd);
      end
      r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_doPush && !i_clear) begin
      r_mem[r_wr] <= i_push_data;
    end
  end

  // Kill-all only touches entries present before the edge; an entry pushed in
  // the same cycle lands with its flag clear (the later assignment wins).
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kill <= '0;
    end else if (i_clear) begin
      r_kill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_all && w_valid[i]) begin
          r_kill[i] <= 1'b1;
        end
      end
      if (w_doPush) begin
        r_kill[r_wr] <= 1'b0;
      end
    end
  end

  // The owner's credit scheme must keep pushes into a full buffer impossible.
  always @(posedge i_clock) begin
    if (i_rst_n && !i_clear) begin
      assert (!(i_push && w_full && !w_doPop));
    end
  end

  assign o_head       = r_mem[r_rd];
  assign o_head_kill  = r_kill[r_rd];
  assign o_count      = r_count;
  assign o_live_count = w_live;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Takes fetch addresses from the program counter, issues in-order requests to
// instruction memory, buffers {address, instruction} pairs for decode and
// drops wrong-path responses after a redirect.
// Ports:
//   clock, reset       : clock, asynchronous active-low reset
//   pc_addr, do_flush  : fetch address and redirect strobe from the PC
//   pc_stall           : holds the PC whenever no request is granted
//   imem_req/addr/gnt  : request handshake to instruction memory
//   imem_rvalid/rdata  : in-order responses from instruction memory
//   out_valid/addr/instruction, out_ready : queue head towards decode
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH           = FETCH_QUEUE_DEPTH,
  parameter int MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  input  logic        do_flush,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_addr,
  output logic [31:0] out_instruction,
  input  logic        out_ready
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

  tracker_entry_t w_trkPushData;
  tracker_entry_t w_trkHead;
  logic           w_trkHeadKill;
  logic [TCW-1:0] w_trkCount;
  logic [TCW-1:0] w_trkLive;
  logic           w_trkEmpty;

  fetch_entry_t   w_qPushData;
  fetch_entry_t   w_qHead;
  logic           w_qHeadKill;
  logic [QCW-1:0] w_qCount;
  logic [QCW-1:0] w_qLive;
  logic [QCW-1:0] w_occEff;
  logic           w_qPush;
  logic           w_qPop;

  logic           w_grant;
  logic           w_respLive;
  logic           w_unused_queue;

  // Credit uses registered counts only, so a pop this cycle frees a slot next
  // cycle. A flush empties the queue at this edge, so its occupancy is free now.
  // Killed requests will be discarded and so do not reserve queue space.
  assign w_occEff = do_flush ? '0 : w_qCount;
  assign imem_req = reset
                 && (int'(w_trkCount) < MAX_OUTSTANDING)
                 && ((int'(w_trkLive) + int'(w_occEff)) < DEPTH);
  assign w_grant   = imem_req && imem_gnt;
  assign pc_stall  = !w_grant;
  assign imem_addr = pc_addr;

  assign w_trkPushData = '{addr: pc_addr, kill: 1'b0};
  assign w_trkEmpty    = (w_trkCount == '0);

  // Responses with no tracked request are ignored; killed or flush-cycle
  // responses are consumed from the tracker but never reach the queue.
  assign w_respLive  = imem_rvalid && !w_trkEmpty && !w_trkHead.kill && !w_trkHeadKill;
  assign w_qPush     = w_respLive && !do_flush;
  assign w_qPushData = '{addr: w_trkHead.addr, instruction: imem_rdata};
  assign w_qPop      = out_valid && out_ready;

  sync_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (tracker_entry_t)
  ) u_tracker (
    .i_clock      (clock),
    .i_rst_n      (reset),
    .i_push       (w_grant),
    .i_push_data  (w_trkPushData),
    .i_pop        (imem_rvalid),
    .i_clear      (1'b0),
    .i_kill_all   (do_flush),
    .o_head       (w_trkHead),
    .o_head_kill  (w_trkHeadKill),
    .o_count      (w_trkCount),
    .o_live_count (w_trkLive)
  );

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_queue (
    .i_clock      (clock),
    .i_rst_n      (reset),
    .i_push       (w_qPush),
    .i_push_data  (w_qPushData),
    .i_pop        (w_qPop),
    .i_clear      (do_flush),
    .i_kill_all   (1'b0),
    .o_head       (w_qHead),
    .o_head_kill  (w_qHeadKill),
    .o_count      (w_qCount),
    .o_live_count (w_qLive)
  );

  // The queue never uses kill flags.
  assign w_unused_queue = ^{w_qHeadKill, w_qLive};

  assign out_valid       = (w_qCount != '0);
  assign out_addr        = out_valid ? w_qHead.addr        : '0;
  assign out_instruction = out_valid ? w_qHead.instruction : '0;

endmodule
